ram_arbiter: RTL and testbench

- Shares the single 16-bit asynchronous SRAM (18-bit halfword address) between the instruction-fetch port and the data-memory port of the pipelined MIPS core.
- Converts 32-bit byte-addressed requests into one or two timed SRAM halfword phases and drives the SRAM control strobes.
- Sits between the fetch/memory stages and the external Ram, replacing direct SRAM wiring.

---
 rtl/ram_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Shares one 16-bit asynchronous SRAM between the instruction-fetch and data-memory ports.
// Define ARB_RR_EN for round-robin arbitration; otherwise dm has fixed priority over if.

module ram_arbiter #(
    parameter int RAM_WAIT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [1:0]  dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic [17:0] addr,
    inout  wire  [15:0] data,
    output logic        wre,
    output logic        oute,
    output logic        hb_mask,
    output logic        lb_mask,
    output logic        chip_en
);
    typedef enum logic [1:0] {ST_IDLE, ST_PH0, ST_PH1, ST_DONE} state_t;

    localparam logic [2:0] LAST_CNT = 3'(RAM_WAIT);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        gnt_dm_q, gnt_dm_d;
    logic        we_q, we_d;
    logic        word_q, word_d;
    logic        byte_q, byte_d;
    logic        lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] hi_q, hi_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        wre_q, wre_d;
    logic        oute_q, oute_d;
    logic        hb_q, hb_d;
    logic        lb_q, lb_d;
    logic        ce_q, ce_d;
    logic        drv_q, drv_d;
    logic [15:0] wr_q, wr_d;

    logic        pref_dm;
    logic        gnt;
    logic        phase_end;
    logic        in_phase_d;
    logic [31:0] rd_word;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[31:19], if_addr[1:0], dm_addr[31:19]};

`ifdef ARB_RR_EN
    logic rr_q, rr_d;
    assign pref_dm = rr_q;
`else
    assign pref_dm = 1'b1;
`endif

    assign phase_end = (cnt_q == LAST_CNT);

    // Read result assembled at the edge that closes the final phase.
    always_comb begin
        rd_word = {16'h0000, data};
        if (word_q) begin
            rd_word = {hi_q, data};
        end else if (byte_q) begin
            rd_word = {24'h000000, (lane_q ? data[7:0] : data[15:8])};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_dm_d   = gnt_dm_q;
        we_d       = we_q;
        word_d     = word_q;
        byte_d     = byte_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        hi_d       = hi_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        gnt        = 1'b0;
`ifdef ARB_RR_EN
        rr_d       = rr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dm_req || if_req) begin
                    gnt      = dm_req && (!if_req || pref_dm);
                    gnt_dm_d = gnt;
                    cnt_d    = 3'd0;
                    state_d  = ST_PH0;
                    if (gnt) begin
                        we_d    = dm_we;
                        word_d  = dm_size[1];
                        byte_d  = (dm_size == 2'b00);
                        lane_d  = dm_addr[0];
                        wdata_d = dm_wdata;
                        addr_d  = dm_size[1] ? {dm_addr[18:2], 1'b0} : dm_addr[18:1];
                    end else begin
                        we_d    = 1'b0;
                        word_d  = 1'b1;
                        byte_d  = 1'b0;
                        lane_d  = 1'b0;
                        wdata_d = 32'h0;
                        addr_d  = {if_addr[18:2], 1'b0};
                    end
`ifdef ARB_RR_EN
                    // Only a contended grant moves the preference to the other port.
                    if (dm_req && if_req) begin
                        rr_d = !gnt;
                    end
`endif
                end
            end
            ST_PH0: begin
                if (phase_end) begin
                    cnt_d = 3'd0;
                    if (word_q) begin
                        hi_d    = data;
                        addr_d  = {addr_q[17:1], 1'b1};
                        state_d = ST_PH1;
                    end else begin
                        state_d = ST_DONE;
                        if (!we_q && gnt_dm_q) begin
                            dm_rdata_d = rd_word;
                        end else if (!we_q) begin
                            if_rdata_d = rd_word;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_PH1: begin
                if (phase_end) begin
                    cnt_d   = 3'd0;
                    state_d = ST_DONE;
                    if (!we_q && gnt_dm_q) begin
                        dm_rdata_d = rd_word;
                    end else if (!we_q) begin
                        if_rdata_d = rd_word;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SRAM strobes are registered from next-state values so they never glitch.
    always_comb begin
        in_phase_d = (state_d == ST_PH0) || (state_d == ST_PH1);
        ce_d       = !in_phase_d;
        oute_d     = !(in_phase_d && !we_d);
        wre_d      = !(in_phase_d && we_d && (cnt_d < LAST_CNT));
        hb_d       = !(in_phase_d && (!byte_d || !lane_d));
        lb_d       = !(in_phase_d && (!byte_d || lane_d));
        drv_d      = in_phase_d && we_d;
        wr_d       = wdata_d[15:0];
        if (word_d && (state_d == ST_PH0)) begin
            wr_d = wdata_d[31:16];
        end else if (byte_d) begin
            wr_d = {2{wdata_d[7:0]}};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            gnt_dm_q   <= 1'b0;
            we_q       <= 1'b0;
            word_q     <= 1'b0;
            byte_q     <= 1'b0;
            lane_q     <= 1'b0;
            wdata_q    <= 32'h0;
            addr_q     <= 18'h0;
            hi_q       <= 16'h0;
            if_rdata_q <= 32'h0;
            dm_rdata_q <= 32'h0;
            wre_q      <= 1'b1;
            oute_q     <= 1'b1;
            hb_q       <= 1'b1;
            lb_q       <= 1'b1;
            ce_q       <= 1'b1;
            drv_q      <= 1'b0;
            wr_q       <= 16'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_dm_q   <= gnt_dm_d;
            we_q       <= we_d;
            word_q     <= word_d;
            byte_q     <= byte_d;
            lane_q     <= lane_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            hi_q       <= hi_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            wre_q      <= wre_d;
            oute_q     <= oute_d;
            hb_q       <= hb_d;
            lb_q       <= lb_d;
            ce_q       <= ce_d;
            drv_q      <= drv_d;
            wr_q       <= wr_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign addr     = addr_q;
    assign data     = drv_q ? wr_q : 16'hzzzz;
    assign wre      = wre_q;
    assign oute     = oute_q;
    assign hb_mask  = hb_q;
    assign lb_mask  = lb_q;
    assign chip_en  = ce_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign if_ack   = (state_q == ST_DONE) && !gnt_dm_q;
    assign dm_ack   = (state_q == ST_DONE) && gnt_dm_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: two instances (RAM_WAIT=1 and 2), each with a behavioural SRAM.
module tb_ram_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // instance 0 (RAM_WAIT=1)
    logic        if_req = 0, dm_req = 0, dm_we = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
    logic [1:0]  dm_size = 0;
    logic [31:0] if_rdata, dm_rdata;
    logic        if_ack, dm_ack;
    logic [17:0] addr0;
    wire  [15:0] data0;
    logic        wre0, oute0, hb0, lb0, ce0;

    // instance 1 (RAM_WAIT=2), data port only
    logic        if2_req = 0, dm2_req = 0, dm2_we = 0;
    logic [31:0] if2_addr = 0, dm2_addr = 0, dm2_wdata = 0;
    logic [1:0]  dm2_size = 0;
    logic [31:0] if2_rdata, dm2_rdata;
    logic        if2_ack, dm2_ack;
    logic [17:0] addr1;
    wire  [15:0] data1;
    logic        wre1, oute1, hb1, lb1, ce1;

    ram_arbiter #(.RAM_WAIT(1)) u_dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .addr(addr0), .data(data0), .wre(wre0), .oute(oute0),
        .hb_mask(hb0), .lb_mask(lb0), .chip_en(ce0)
    );

    ram_arbiter #(.RAM_WAIT(2)) u_dut2 (
        .clock(clock), .reset(reset),
        .if_req(if2_req), .if_addr(if2_addr), .if_rdata(if2_rdata), .if_ack(if2_ack),
        .dm_req(dm2_req), .dm_we(dm2_we), .dm_size(dm2_size), .dm_addr(dm2_addr),
        .dm_wdata(dm2_wdata), .dm_rdata(dm2_rdata), .dm_ack(dm2_ack),
        .addr(addr1), .data(data1), .wre(wre1), .oute(oute1),
        .hb_mask(hb1), .lb_mask(lb1), .chip_en(ce1)
    );

    // Behavioural SRAMs: read drives the bus, write commits at each clock seen with wre low.
    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];
    logic        pl_en = 0, pl_sel = 0;
    logic [17:0] pl_a = 0;
    logic [15:0] pl_d = 0;

    assign data0 = (!ce0 && !oute0) ? mem0[addr0] : 16'hzzzz;
    assign data1 = (!ce1 && !oute1) ? mem1[addr1] : 16'hzzzz;

    always @(posedge clock) begin
        if (pl_en && !pl_sel) begin
            mem0[pl_a] <= pl_d;
        end else if (!ce0 && !wre0) begin
            if (!hb0) mem0[addr0][15:8] <= data0[15:8];
            if (!lb0) mem0[addr0][7:0]  <= data0[7:0];
        end
        if (pl_en && pl_sel) begin
            mem1[pl_a] <= pl_d;
        end else if (!ce1 && !wre1) begin
            if (!hb1) mem1[addr1][15:8] <= data1[15:8];
            if (!lb1) mem1[addr1][7:0]  <= data1[7:0];
        end
    end

    logic [17:0] tr_addr [16];
    logic        tr_wre  [16];
    logic        tr_hb   [16];
    logic        tr_lb   [16];
    int          tr_n;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic preload(input logic sel, input logic [17:0] a, input logic [15:0] d);
        @(negedge clock);
        pl_en = 1; pl_sel = sel; pl_a = a; pl_d = d;
        @(posedge clock);
        #1 pl_en = 0;
    endtask

    // One access; lat = edges after the sampling edge until ack is seen (-1 on timeout).
    task automatic run_access(input logic u2, input logic is_if, input logic we,
                              input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output int lat);
        int   k;
        logic got, ack;
        @(negedge clock);
        if (u2) begin
            dm2_req = 1; dm2_we = we; dm2_size = sz; dm2_addr = a; dm2_wdata = wd;
        end else if (is_if) begin
            if_req = 1; if_addr = a;
        end else begin
            dm_req = 1; dm_we = we; dm_size = sz; dm_addr = a; dm_wdata = wd;
        end
        k = 0; got = 0; tr_n = 0; rd = 0;
        while (!got && k < 40) begin
            @(posedge clock);
            k++;
            @(negedge clock);
            ack = u2 ? dm2_ack : (is_if ? if_ack : dm_ack);
            if (ack) begin
                got = 1;
                rd  = u2 ? dm2_rdata : (is_if ? if_rdata : dm_rdata);
            end else if (tr_n < 16) begin
                tr_addr[tr_n] = u2 ? addr1 : addr0;
                tr_wre[tr_n]  = u2 ? wre1 : wre0;
                tr_hb[tr_n]   = u2 ? hb1 : hb0;
                tr_lb[tr_n]   = u2 ? lb1 : lb0;
                tr_n++;
            end
        end
        lat = got ? k - 1 : -1;
        if (!got) chk("ack_timeout", {31'b0, got}, 32'h1);
        dm_req = 0; if_req = 0; dm2_req = 0;
        @(posedge clock);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat, k, dm_k, if_k;
        logic [31:0] dm_rd, if_rd;
        logic [17:0] ea [6];

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_strobes", {25'b0, wre0, oute0, hb0, lb0, ce0, if_ack, dm_ack}, 32'h7C);
        chk("rst_addr", {14'b0, addr0}, 32'h0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'h0);
        reset = 1;

        // reset during PH0 of a word write
        preload(0, 18'h0C0, 16'h1111);
        @(negedge clock);
        dm_req = 1; dm_we = 1; dm_size = 2'b10; dm_addr = 32'h180; dm_wdata = 32'hDEADBEEF;
        @(posedge clock);
        @(negedge clock);
        chk("t1_wre_low", {31'b0, wre0}, 32'h0);
        reset = 0;
        #1;
        chk("t1_abort_strobes", {27'b0, wre0, ce0, oute0, if_ack, dm_ack}, 32'h1C);
        chk("t1_abort_addr", {14'b0, addr0}, 32'h0);
        dm_req = 0; dm_we = 0;
        @(negedge clock);
        reset = 1;
        repeat (2) @(posedge clock);
        chk("t1_sram_untouched", {16'b0, mem0[18'h0C0]}, 32'h1111);

        // word fetch at 0x100
        preload(0, 18'h080, 16'h1234);
        preload(0, 18'h081, 16'hABCD);
        run_access(0, 1, 0, 2'b10, 32'h00000100, 32'h0, rd, lat);
        chk("t2_rdata", rd, 32'h1234ABCD);
        chk("t2_lat", lat, 32'd4);
        ea = '{18'h080, 18'h080, 18'h081, 18'h081, 18'h0, 18'h0};
        for (int i = 0; i < 4; i++) chk($sformatf("t2_addr%0d", i), {14'b0, tr_addr[i]}, {14'b0, ea[i]});
        chk("t2_no_write", {31'b0, tr_wre[0] & tr_wre[1] & tr_wre[2] & tr_wre[3]}, 32'h1);

        // fetch above 512 KiB wraps
        run_access(0, 1, 0, 2'b10, 32'h00080100, 32'h0, rd, lat);
        chk("wrap_rdata", rd, 32'h1234ABCD);

        // byte write 0x5A at 0x203
        preload(0, 18'h101, 16'hFFFF);
        run_access(0, 0, 1, 2'b00, 32'h00000203, 32'h1234565A, rd, lat);
        chk("t3_lat", lat, 32'd2);
        chk("t3_phase", {12'b0, tr_addr[0], tr_hb[0], tr_lb[0]}, {12'b0, 18'h101, 1'b1, 1'b0});
        chk("t3_wre", {30'b0, tr_wre[0], tr_wre[1]}, 32'h1);
        chk("t3_sram", {16'b0, mem0[18'h101]}, 32'hFF5A);

        // halfword and byte reads
        preload(0, 18'h101, 16'hBEEF);
        run_access(0, 0, 0, 2'b01, 32'h00000202, 32'h0, rd, lat);
        chk("t4_half", rd, 32'h0000BEEF);
        chk("t4_half_masks", {30'b0, tr_hb[0], tr_lb[0]}, 32'h0);
        run_access(0, 0, 0, 2'b00, 32'h00000202, 32'h0, rd, lat);
        chk("t4_byte_hi", rd, 32'h000000BE);
        run_access(0, 0, 0, 2'b00, 32'h00000203, 32'h0, rd, lat);
        chk("t4_byte_lo", rd, 32'h000000EF);

        // word write is big-endian across the two phases; read data holds
        run_access(0, 0, 1, 2'b10, 32'h00000300, 32'h11223344, rd, lat);
        chk("ww_lat", lat, 32'd4);
        chk("ww_wre", {28'b0, tr_wre[0], tr_wre[1], tr_wre[2], tr_wre[3]}, 32'h5);
        chk("ww_hi", {16'b0, mem0[18'h180]}, 32'h1122);
        chk("ww_lo", {16'b0, mem0[18'h181]}, 32'h3344);
        chk("rdata_hold", dm_rdata, 32'h000000EF);

        // contention, two rounds
        for (int r = 0; r < 2; r++) begin
            @(negedge clock);
            dm_req = 1; dm_we = 0; dm_size = 2'b01; dm_addr = 32'h202;
            if_req = 1; if_addr = 32'h100;
            k = 0; dm_k = -1; if_k = -1; dm_rd = 0; if_rd = 0;
            while ((dm_k < 0 || if_k < 0) && k < 40) begin
                @(posedge clock);
                k++;
                @(negedge clock);
                if (dm_ack) begin dm_k = k - 1; dm_rd = dm_rdata; dm_req = 0; end
                if (if_ack) begin if_k = k - 1; if_rd = if_rdata; if_req = 0; end
            end
            dm_req = 0; if_req = 0;
            @(posedge clock);
            chk($sformatf("t5_r%0d_dm_rdata", r), dm_rd, 32'h0000BEEF);
            chk($sformatf("t5_r%0d_if_rdata", r), if_rd, 32'h1234ABCD);
`ifdef ARB_RR_EN
            chk($sformatf("t5_r%0d_dm_lat", r), dm_k, (r == 0) ? 32'd2 : 32'd8);
            chk($sformatf("t5_r%0d_if_lat", r), if_k, (r == 0) ? 32'd8 : 32'd4);
`else
            chk($sformatf("t5_r%0d_dm_lat", r), dm_k, 32'd2);
            chk($sformatf("t5_r%0d_if_lat", r), if_k, 32'd8);
`endif
        end

        // RAM_WAIT=2 instance
        preload(1, 18'h080, 16'hCAFE);
        preload(1, 18'h081, 16'hF00D);
        run_access(1, 0, 0, 2'b10, 32'h00080103, 32'h0, rd, lat);
        chk("t6_rdata", rd, 32'hCAFEF00D);
        chk("t6_lat", lat, 32'd6);
        ea = '{18'h080, 18'h080, 18'h080, 18'h081, 18'h081, 18'h081};
        for (int i = 0; i < 6; i++) chk($sformatf("t6_addr%0d", i), {14'b0, tr_addr[i]}, {14'b0, ea[i]});
        run_access(1, 0, 1, 2'b10, 32'h00000204, 32'hA5A55A5A, rd, lat);
        chk("t6_wr_lat", lat, 32'd6);
        chk("t6_wr_wre", {26'b0, tr_wre[0], tr_wre[1], tr_wre[2], tr_wre[3], tr_wre[4], tr_wre[5]}, 32'h09);
        chk("t6_wr_hi", {16'b0, mem1[18'h102]}, 32'hA5A5);
        chk("t6_wr_lo", {16'b0, mem1[18'h103]}, 32'h5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
